// File: rtl/exe_mem_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | exe_mem_reg: EXE/MEM pipeline register plus architectural NZCV flags.  |
// | Optional macro EXE_MEM_PERF_CNT_EN adds a retired-instruction counter. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module exe_mem_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  s_in,
  input  logic [DATA_W-1:0]     alu_res_in,
  input  logic [3:0]            status_alu_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  valid_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [3:0]            status_out,
`ifdef EXE_MEM_PERF_CNT_EN
  output logic [31:0]           retire_cnt_out,
`endif
  output logic                  carry_out
);

  logic w_capture;
  assign w_capture = !flush_in && !freeze_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_res_out  <= '0;
      val_rm_out   <= '0;
      dest_out     <= '0;
      status_out   <= 4'b0000;
    end else if (flush_in) begin
      // Killed instruction becomes a clean bubble; flags are untouched.
      valid_out    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_res_out  <= '0;
      val_rm_out   <= '0;
      dest_out     <= '0;
    end else if (!freeze_in) begin
      valid_out    <= valid_in;
      wb_en_out    <= wb_en_in && valid_in;
      mem_r_en_out <= mem_r_en_in && valid_in;
      mem_w_en_out <= mem_w_en_in && valid_in;
      alu_res_out  <= alu_res_in;
      val_rm_out   <= val_rm_in;
      dest_out     <= dest_in;
      if (valid_in && s_in) begin
        status_out <= status_alu_in;
      end
    end
  end

  // Registered C only: ADC/SBC chains see the carry from the previous cycle.
  assign carry_out = status_out[1];

`ifdef EXE_MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt_out <= 32'd0;
    end else if (w_capture && valid_in) begin
      retire_cnt_out <= retire_cnt_out + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst && w_capture && valid_in) begin
      assert (!(mem_r_en_in && mem_w_en_in))
        else $error("exe_mem_reg: load and store both asserted on a valid instruction");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_mem_reg.sv
`default_nettype none
// Directed self-checking bench for exe_mem_reg.
module tb_exe_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze_in, flush_in, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  status_alu_in, dest_in;
  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, carry_out;
  logic [31:0] alu_res_out, val_rm_out;
  logic [3:0]  dest_out, status_out;
`ifdef EXE_MEM_PERF_CNT_EN
  logic [31:0] retire_cnt_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_mem_reg dut (
    .clk(clk), .rst(rst), .freeze_in(freeze_in), .flush_in(flush_in),
    .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .s_in(s_in), .alu_res_in(alu_res_in),
    .status_alu_in(status_alu_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
    .dest_out(dest_out), .status_out(status_out),
`ifdef EXE_MEM_PERF_CNT_EN
    .retire_cnt_out(retire_cnt_out),
`endif
    .carry_out(carry_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef EXE_MEM_PERF_CNT_EN
    check(tag, retire_cnt_out, exp);
`endif
  endtask

  initial begin
    // Reset with every input driven high, including freeze and flush.
    rst = 1'b0; freeze_in = 1'b1; flush_in = 1'b1; valid_in = 1'b1; wb_en_in = 1'b1;
    mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; s_in = 1'b1;
    alu_res_in = 32'hFFFF_FFFF; val_rm_in = 32'hFFFF_FFFF;
    status_alu_in = 4'hF; dest_in = 4'hF;
    step(); step();
    check("rst_valid", valid_out, 0);
    check("rst_wb", wb_en_out, 0);
    check("rst_memr", mem_r_en_out, 0);
    check("rst_memw", mem_w_en_out, 0);
    check("rst_alu", alu_res_out, 0);
    check("rst_rm", val_rm_out, 0);
    check("rst_dest", dest_out, 0);
    check("rst_status", status_out, 0);
    check("rst_carry", carry_out, 0);
    check_cnt("rst_cnt", 0);

    freeze_in = 0; flush_in = 0; valid_in = 0; wb_en_in = 0; mem_r_en_in = 0;
    mem_w_en_in = 0; s_in = 0; alu_res_in = 0; val_rm_in = 0; status_alu_in = 0; dest_in = 0;
    rst = 1'b1;
    step();

    // Normal capture
    valid_in = 1; wb_en_in = 1; s_in = 1; alu_res_in = 32'h8000_0000;
    status_alu_in = 4'b1010; dest_in = 4'd3; val_rm_in = 32'hDEAD_BEEF;
    step();
    check("cap_alu", alu_res_out, 32'h8000_0000);
    check("cap_dest", dest_out, 3);
    check("cap_wb", wb_en_out, 1);
    check("cap_valid", valid_out, 1);
    check("cap_rm", val_rm_out, 32'hDEAD_BEEF);
    check("cap_status", status_out, 4'b1010);
    check("cap_carry", carry_out, 1);
    check_cnt("cap_cnt", 1);

    // S bit clear holds flags, data still moves
    status_alu_in = 4'b0010;
    step();
    check("s_set_status", status_out, 4'b0010);
    s_in = 0; status_alu_in = 4'b0100; alu_res_in = 32'h5555; dest_in = 4'd7; mem_r_en_in = 1;
    step();
    check("s_clr_status", status_out, 4'b0010);
    check("s_clr_alu", alu_res_out, 32'h5555);
    check("s_clr_dest", dest_out, 7);
    check("s_clr_memr", mem_r_en_out, 1);
    check_cnt("s_clr_cnt", 3);

    // Freeze holds everything for 3 cycles
    mem_r_en_in = 0; alu_res_in = 32'h1234;
    step();
    freeze_in = 1; alu_res_in = 32'hFFFF; s_in = 1; status_alu_in = 4'b1111; dest_in = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_alu", alu_res_out, 32'h1234);
      check("frz_status", status_out, 4'b0010);
    end
    check("frz_dest", dest_out, 7);
    check_cnt("frz_cnt", 4);

    // Flush wins over freeze
    flush_in = 1; valid_in = 1; mem_w_en_in = 1;
    step();
    check("fl_valid", valid_out, 0);
    check("fl_memw", mem_w_en_out, 0);
    check("fl_alu", alu_res_out, 0);
    check("fl_dest", dest_out, 0);
    check("fl_status", status_out, 4'b0010);
    check_cnt("fl_cnt", 4);

    // Bubble: controls gated, data loads, flags hold
    freeze_in = 0; flush_in = 0; valid_in = 0; wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 0;
    alu_res_in = 32'hABCD; s_in = 1; status_alu_in = 4'b1111;
    step();
    check("bub_valid", valid_out, 0);
    check("bub_wb", wb_en_out, 0);
    check("bub_memr", mem_r_en_out, 0);
    check("bub_alu", alu_res_out, 32'hABCD);
    check("bub_status", status_out, 4'b0010);
    check_cnt("bub_cnt", 4);

    // ADC chain timing
    valid_in = 1; mem_r_en_in = 0; status_alu_in = 4'b0000;
    step();
    check("adc_clr_carry", carry_out, 0);
    check_cnt("adc_cnt0", 5);
    status_alu_in = 4'b0010;
    step();
    check("adc_add_carry", carry_out, 1);
    check_cnt("adc_cnt1", 6);
    status_alu_in = 4'b0000;
    #1;
    check("adc_no_comb", carry_out, 1);
    step();
    check("adc_next_carry", carry_out, 0);
    check_cnt("adc_cnt2", 7);
    valid_in = 0;
    step();
    check_cnt("adc_bub_cnt", 7);

    // Mid-operation reset together with freeze
    valid_in = 1; status_alu_in = 4'b1001; alu_res_in = 32'h77;
    step();
    check("pre_rst_status", status_out, 4'b1001);
    rst = 0; freeze_in = 1;
    step();
    check("mid_rst_status", status_out, 0);
    check("mid_rst_alu", alu_res_out, 0);
    check("mid_rst_valid", valid_out, 0);
    check_cnt("mid_rst_cnt", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
